// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants: architectural widths, PC step and
// the FIFO entry layout carried from the memory response to decode.
package instr_fetch_pkg;

    localparam int unsigned XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode
// delivery and redirect. master = fetch unit, slave = its environment.
interface instr_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO with flush and registered storage; head is read straight
// from the storage array. A push into a full FIFO is accepted when paired with a pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       head_valid_o,
    output logic [WIDTH-1:0]           head_data_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited word reads, tags responses
// with their request PC and discards responses made stale by a redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [31:0]   tag_q [MAX_OUTST];
    logic [TW-1:0] tag_wr_q, tag_wr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_valid;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          fifo_push, fifo_pop;
    logic          credit_ok, req_valid, req_fire;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] ptr);
        return (ptr == TW'(MAX_OUTST - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Credits count words already buffered plus words still in flight.
    assign credit_ok = (32'(outst_q) < MAX_OUTST) &&
                       ((32'(fifo_count) + 32'(outst_q)) < DEPTH);
    assign req_valid = !reset && !bus.redirect_valid && credit_ok;
    assign req_fire  = req_valid && bus.imem_req_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        fifo_push = 1'b0;

        if (req_fire) begin
            pc_d     = pc_q + PC_INC;
            outst_d  = outst_d + 1'b1;
            tag_wr_d = tag_next(tag_wr_q);
        end
        // Tags retire with every response, kept or dropped, to stay in step with memory.
        if (bus.imem_rsp_valid) begin
            outst_d  = outst_d - 1'b1;
            tag_rd_d = tag_next(tag_rd_q);
        end

        unique case (state_q)
            ST_RUN: begin
                if (bus.imem_rsp_valid) fifo_push = 1'b1;
            end
            ST_DRAIN: begin
                if (bus.imem_rsp_valid) begin
                    drop_d = drop_q - 1'b1;
                    if (drop_q == OW'(1)) state_d = ST_RUN;
                end
            end
        endcase

        // Redirect overrides: everything still in flight after this edge is stale.
        if (bus.redirect_valid) begin
            pc_d      = word_align(bus.redirect_pc);
            drop_d    = outst_d;
            state_d   = (outst_d != '0) ? ST_DRAIN : ST_RUN;
            fifo_push = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr_q] <= pc_q;
    end

    assign push_entry = '{instr: bus.imem_rsp_data, pc: tag_q[tag_rd_q]};
    assign fifo_pop   = fifo_valid && bus.instr_ready;

    fetch_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .flush_i     (bus.redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .count_o     (fifo_count),
        .head_valid_o(fifo_valid),
        .head_data_o (fifo_head)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = fifo_valid;
    assign bus.instr          = fifo_head.instr;
    assign bus.instr_pc       = fifo_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model returning addr^A5A5_0000, a stream-level
// reference (next expected PC / next expected request address) and directed corners.
module tb_instr_fetch;

    localparam int unsigned DEPTH     = 2;
    localparam int unsigned MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] XORK      = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int unsigned pops   = 0;
    int          mem_mode = 0;   // 0: fixed 1-cycle, 1: random latency, 2: hold responses
    logic [31:0] mem_q [$];
    int unsigned mem_t [$];
    logic [31:0] exp_pc, exp_addr;

    logic        o_rv, o_iv, o_pop;
    logic [31:0] o_addr, o_instr, o_pc, o_pop_pc;

    typedef struct {
        logic        ir;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory response, sample outputs, update reference.
    task automatic tick();
        bit rsp;
        rsp = 1'b0;
        if (!reset && mem_q.size() != 0 && mem_t[0] < cyc) begin
            if (mem_mode == 0)      rsp = 1'b1;
            else if (mem_mode == 1) rsp = ($urandom_range(0, 1) == 1);
        end
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? (mem_q[0] ^ XORK) : 32'hDEAD_BEEF;
        #1;
        o_rv    = bus.imem_req_valid;
        o_addr  = bus.imem_addr;
        o_iv    = bus.instr_valid;
        o_instr = bus.instr;
        o_pc    = bus.instr_pc;
        o_pop   = 1'b0;
        if (!reset) begin
            if (bus.redirect_valid) check("no_req_on_redirect", {31'b0, o_rv}, 32'd0);
            if (o_rv && bus.imem_req_ready) begin
                check("req_addr", o_addr, exp_addr);
                mem_q.push_back(o_addr);
                mem_t.push_back(cyc);
                exp_addr = exp_addr + 32'd4;
                check("outst_bound", (mem_q.size() <= MAX_OUTST) ? 32'd1 : 32'd0, 32'd1);
            end
            if (rsp) begin
                void'(mem_q.pop_front());
                void'(mem_t.pop_front());
            end
            if (o_iv && bus.instr_ready && !bus.redirect_valid) begin
                check("pop_pc", o_pc, exp_pc);
                check("pop_word", o_instr, exp_pc ^ XORK);
                o_pop    = 1'b1;
                o_pop_pc = o_pc;
                exp_pc   = exp_pc + 32'd4;
                pops++;
            end
            if (bus.redirect_valid) begin
                exp_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
                exp_addr = exp_pc;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        mem_q.delete();
        mem_t.delete();
        tick();
        tick();
        check("rst_req_valid", {31'b0, o_rv}, 32'd0);
        check("rst_instr_valid", {31'b0, o_iv}, 32'd0);
        check("rst_instr", o_instr, 32'd0);
        check("rst_instr_pc", o_pc, 32'd0);
        check("rst_addr", o_addr, RESET_PC);
        reset    = 1'b0;
        exp_pc   = RESET_PC;
        exp_addr = RESET_PC;
        mem_mode = 0;
    endtask

    task automatic wait_pops(input int unsigned n, input int unsigned budget,
                             input logic [31:0] first, input string name, input bit rnd);
        int unsigned got = 0;
        int unsigned k   = 0;
        while (got < n && k < budget) begin
            if (rnd) begin
                bus.imem_req_ready = 1'($urandom_range(0, 1));
                bus.instr_ready    = ($urandom_range(0, 3) != 0);
            end
            tick();
            k++;
            if (o_pop) begin
                if (got == 0) check(name, o_pop_pc, first);
                got++;
            end
        end
        check({name, "_count"}, got, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned p0;
        reset              = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;

        // Cycle-exact start-up with a 1-cycle memory, then a short decode stall.
        vt[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        vt[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        vt[2]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd0};
        vt[3]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        vt[4]  = '{1'b1, 1'b1, 32'd12, 1'b0, 32'd0};
        vt[5]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8};
        vt[6]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
        vt[7]  = '{1'b1, 1'b1, 32'd20, 1'b0, 32'd0};
        vt[8]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd16};
        vt[9]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd16};
        vt[10] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
        vt[11] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd20};

        apply_reset();
        for (int i = 0; i < 12; i++) begin
            bus.instr_ready = vt[i].ir;
            tick();
            check($sformatf("vec%0d_req_valid", i), {31'b0, o_rv}, {31'b0, vt[i].rv});
            if (vt[i].rv) check($sformatf("vec%0d_addr", i), o_addr, vt[i].addr);
            check($sformatf("vec%0d_instr_valid", i), {31'b0, o_iv}, {31'b0, vt[i].iv});
            if (vt[i].iv) check($sformatf("vec%0d_instr_pc", i), o_pc, vt[i].ipc);
        end

        // Long decode stall: FIFO fills, issue stops, nothing left in flight.
        bus.instr_ready = 1'b0;
        repeat (10) tick();
        check("stall_req_valid", {31'b0, o_rv}, 32'd0);
        check("stall_instr_valid", {31'b0, o_iv}, 32'd1);
        check("stall_mem_idle", mem_q.size(), 32'd0);
        bus.instr_ready = 1'b1;
        wait_pops(10, 60, exp_pc, "stall_resume", 1'b0);

        // Redirect with two requests held in memory.
        apply_reset();
        mem_mode = 2;
        tick();
        tick();
        tick();
        check("outst_full_req_valid", {31'b0, o_rv}, 32'd0);
        check("outst_full_count", mem_q.size(), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        mem_mode = 0;
        wait_pops(1, 30, 32'h0000_0100, "redir100_first", 1'b0);
        wait_pops(1, 30, 32'h0000_0104, "redir100_second", 1'b0);

        // Redirect coinciding with a response and a pop.
        apply_reset();
        repeat (5) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0040;
        tick();
        check("redir_pop_instr_valid", {31'b0, o_iv}, 32'd1);
        bus.redirect_valid = 1'b0;
        tick();
        check("redir_flush_empty", {31'b0, o_iv}, 32'd0);
        wait_pops(2, 30, 32'h0000_0040, "redir40_stream", 1'b0);

        // Random stalls plus back-to-back redirects: only the later target survives.
        apply_reset();
        mem_mode = 1;
        for (int i = 0; i < 6; i++) begin
            bus.imem_req_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        bus.imem_req_ready = 1'($urandom_range(0, 1));
        tick();
        bus.redirect_pc    = 32'h0000_0300;
        bus.imem_req_ready = 1'($urandom_range(0, 1));
        tick();
        bus.redirect_valid = 1'b0;
        wait_pops(8, 200, 32'h0000_0300, "b2b_redirect", 1'b1);

        // Address wrap and ignored low redirect bits.
        apply_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        wait_pops(1, 30, 32'hFFFF_FFFC, "wrap_first", 1'b0);
        wait_pops(1, 30, 32'h0000_0000, "wrap_second", 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check("redir_low_bits_addr", o_addr, 32'h0000_0100);
        wait_pops(2, 30, 32'h0000_0100, "redir_low_bits", 1'b0);

        // Random soak with sporadic redirects and one reset mid-stream.
        apply_reset();
        mem_mode = 1;
        p0 = pops;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                apply_reset();
                mem_mode = 1;
            end
            bus.imem_req_ready = 1'($urandom_range(0, 1));
            bus.instr_ready    = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 39) == 0);
            bus.redirect_pc    = $urandom();
            tick();
        end
        bus.redirect_valid = 1'b0;
        check("soak_progress", ((pops - p0) > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
